// File: rtl/bcd_updown_counter_n.sv
// Multi-decade BCD up/down counter with enable, validated parallel load,
// wrap/saturate bounds and registered terminal-count / load-error pulses.
module bcd_updown_counter_n #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                up_down,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   input  logic                sat_mode,
   output logic [4*DIGITS-1:0] count,
   output logic                tc,
   output logic                load_err
);

   localparam int W = 4*DIGITS;

   logic [W-1:0] up_val;
   logic [W-1:0] dn_val;
   logic         at_max;
   logic         at_min;
   logic         load_ok;

   // Ripple the decade carry/borrow: at_max/at_min hold "all lower digits are 9/0"
   // while walking upward, and end up flagging the full-count bounds.
   always_comb begin
      up_val  = count;
      dn_val  = count;
      at_max  = 1'b1;
      at_min  = 1'b1;
      load_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (load_val[4*i +: 4] > 4'd9)
            load_ok = 1'b0;
         if (at_max)
            up_val[4*i +: 4] = (count[4*i +: 4] == 4'd9) ? 4'd0 : count[4*i +: 4] + 4'd1;
         if (at_min)
            dn_val[4*i +: 4] = (count[4*i +: 4] == 4'd0) ? 4'd9 : count[4*i +: 4] - 4'd1;
         if (count[4*i +: 4] != 4'd9)
            at_max = 1'b0;
         if (count[4*i +: 4] != 4'd0)
            at_min = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count    <= '0;
         tc       <= 1'b0;
         load_err <= 1'b0;
      end else if (load) begin
         tc <= 1'b0;
         if (load_ok) begin
            count    <= load_val;
            load_err <= 1'b0;
         end else begin
            load_err <= 1'b1;
         end
      end else if (en) begin
         load_err <= 1'b0;
         if (up_down) begin
            tc <= at_max;
            if (!(at_max && sat_mode))
               count <= up_val;
         end else begin
            tc <= at_min;
            if (!(at_min && sat_mode))
               count <= dn_val;
         end
      end else begin
         tc       <= 1'b0;
         load_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Bench for bcd_updown_counter_n: vector table on a 4-decade instance plus
// hand-written corner sequences on a single-decade instance.
module tb_bcd_updown_counter_n;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b0, en = 1'b0, up_down = 1'b0, load = 1'b0, sat_mode = 1'b0;
   logic [15:0] load_val = '0;
   logic [15:0] count;
   logic        tc, load_err;

   logic        reset1 = 1'b0, en1 = 1'b0, up_down1 = 1'b0, load1 = 1'b0, sat_mode1 = 1'b0;
   logic [3:0]  load_val1 = '0;
   logic [3:0]  count1;
   logic        tc1, load_err1;

   bcd_updown_counter_n #(.DIGITS(4)) dut4 (
      .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
      .load_val(load_val), .sat_mode(sat_mode),
      .count(count), .tc(tc), .load_err(load_err)
   );

   bcd_updown_counter_n #(.DIGITS(1)) dut1 (
      .clk(clk), .reset(reset1), .en(en1), .up_down(up_down1), .load(load1),
      .load_val(load_val1), .sat_mode(sat_mode1),
      .count(count1), .tc(tc1), .load_err(load_err1)
   );

   typedef struct {
      logic        reset;
      logic        en;
      logic        up_down;
      logic        load;
      logic        sat_mode;
      logic [15:0] load_val;
      logic [15:0] exp_count;
      logic        exp_tc;
      logic        exp_le;
      string       name;
   } vec_t;

   typedef struct {
      logic [15:0] count;
      logic        tc;
      logic        le;
      string       name;
   } exp_t;

   vec_t vecs[$];
   exp_t sb4[$];
   exp_t sb1[$];
   int   applied = 0;
   int   miscompares = 0;

   function automatic void add(input logic r, input logic e, input logic ud, input logic ld,
                               input logic sm, input logic [15:0] lv, input logic [15:0] ec,
                               input logic et, input logic el, input string nm);
      vec_t v;
      v.reset = r; v.en = e; v.up_down = ud; v.load = ld; v.sat_mode = sm;
      v.load_val = lv; v.exp_count = ec; v.exp_tc = et; v.exp_le = el; v.name = nm;
      vecs.push_back(v);
   endfunction

   task automatic check(input logic [15:0] act_c, input logic act_t, input logic act_l,
                        input exp_t x);
      applied++;
      if (act_c !== x.count || act_t !== x.tc || act_l !== x.le) begin
         miscompares++;
         $display("FAIL %s: count=%h tc=%b load_err=%b, required count=%h tc=%b load_err=%b",
                  x.name, act_c, act_t, act_l, x.count, x.tc, x.le);
      end
   endtask

   task automatic apply4(input vec_t v);
      exp_t x;
      reset = v.reset; en = v.en; up_down = v.up_down; load = v.load;
      sat_mode = v.sat_mode; load_val = v.load_val;
      x.count = v.exp_count; x.tc = v.exp_tc; x.le = v.exp_le; x.name = v.name;
      sb4.push_back(x);
      @(posedge clk);
      #1;
      if (sb4.size() == 0) begin
         applied++; miscompares++;
         $display("FAIL %s: scoreboard empty", v.name);
      end else begin
         check(count, tc, load_err, sb4.pop_front());
      end
   endtask

   task automatic apply1(input logic r, input logic e, input logic ud, input logic ld,
                         input logic sm, input logic [3:0] lv, input logic [3:0] ec,
                         input logic et, input logic el, input string nm);
      exp_t x;
      reset1 = r; en1 = e; up_down1 = ud; load1 = ld; sat_mode1 = sm; load_val1 = lv;
      x.count = {12'h000, ec}; x.tc = et; x.le = el; x.name = nm;
      sb1.push_back(x);
      @(posedge clk);
      #1;
      if (sb1.size() == 0) begin
         applied++; miscompares++;
         $display("FAIL %s: scoreboard empty", nm);
      end else begin
         check({12'h000, count1}, tc1, load_err1, sb1.pop_front());
      end
   endtask

   initial begin
      // r en ud ld sm load_val exp_count tc le
      add(1,0,0,0,0,16'h0000,16'h0000,0,0,"reset");
      for (int i = 1; i <= 11; i++)
         add(0,1,1,0,0,16'h0000,16'((i/10)*16 + (i%10)),0,0,"up_from_zero");
      add(0,0,0,1,0,16'h0099,16'h0099,0,0,"load_0099");
      add(0,1,1,0,0,16'h0000,16'h0100,0,0,"up_carry_two_digits");
      add(0,1,0,0,0,16'h0000,16'h0099,0,0,"down_borrow_two_digits");
      add(0,0,0,1,0,16'h0999,16'h0999,0,0,"load_0999");
      add(0,1,1,0,0,16'h0000,16'h1000,0,0,"up_carry_three_digits");
      add(0,0,0,1,0,16'h9999,16'h9999,0,0,"load_max");
      add(0,1,1,0,0,16'h0000,16'h0000,1,0,"wrap_up");
      add(0,1,1,0,0,16'h0000,16'h0001,0,0,"after_wrap_up");
      add(0,1,1,0,0,16'h0000,16'h0002,0,0,"dir_up");
      add(0,1,0,0,0,16'h0000,16'h0001,0,0,"dir_reverse_down");
      add(0,1,1,0,0,16'h0000,16'h0002,0,0,"dir_reverse_up");
      add(0,0,0,1,0,16'h0000,16'h0000,0,0,"load_zero");
      add(0,1,0,0,0,16'h0000,16'h9999,1,0,"wrap_down");
      add(0,1,0,0,0,16'h0000,16'h9998,0,0,"after_wrap_down");
      add(0,0,0,0,0,16'h0000,16'h9998,0,0,"hold");
      add(0,0,0,1,0,16'h1000,16'h1000,0,0,"load_1000");
      add(0,1,0,0,0,16'h0000,16'h0999,0,0,"down_borrow_three");
      add(0,0,0,1,1,16'h9999,16'h9999,0,0,"sat_load_max");
      for (int i = 0; i < 3; i++)
         add(0,1,1,0,1,16'h0000,16'h9999,1,0,"sat_hold_max");
      add(0,0,0,0,1,16'h0000,16'h9999,0,0,"sat_idle_clears_tc");
      add(0,1,0,0,1,16'h0000,16'h9998,0,0,"sat_down_from_max");
      add(0,0,0,1,1,16'h0000,16'h0000,0,0,"sat_load_zero");
      add(0,1,0,0,1,16'h0000,16'h0000,1,0,"sat_hold_min");
      add(0,1,0,0,1,16'h0000,16'h0000,1,0,"sat_hold_min_again");
      add(0,1,1,0,1,16'h0000,16'h0001,0,0,"sat_up_from_min");
      add(0,0,0,1,0,16'h0042,16'h0042,0,0,"load_0042");
      add(0,0,0,1,0,16'h12A4,16'h0042,0,1,"bad_load_digit1");
      add(0,0,0,0,0,16'h0000,16'h0042,0,0,"load_err_one_cycle");
      add(0,1,1,1,0,16'hF000,16'h0042,0,1,"bad_load_top_with_en");
      add(0,1,1,1,0,16'h000A,16'h0042,0,1,"bad_load_digit0");
      add(0,1,1,0,0,16'h0000,16'h0043,0,0,"step_clears_load_err");
      add(0,0,0,1,0,16'h1234,16'h1234,0,0,"load_1234");
      add(0,1,1,1,0,16'h5678,16'h5678,0,0,"load_beats_en");
      add(0,0,0,1,0,16'h0457,16'h0457,0,0,"load_0457");
      add(1,1,1,1,0,16'h1111,16'h0000,0,0,"reset_beats_load_en");
      add(0,1,1,0,0,16'h0000,16'h0001,0,0,"resume_after_reset");
      add(0,0,0,1,0,16'h9999,16'h9999,0,0,"load_max_again");
      add(0,1,1,0,0,16'h0000,16'h0000,1,0,"wrap_up_again");
      add(1,0,0,0,0,16'h0000,16'h0000,0,0,"reset_clears_tc");
      add(0,0,0,1,0,16'hAAAA,16'h0000,0,1,"bad_load_all");
      add(1,0,0,1,0,16'hAAAA,16'h0000,0,0,"reset_clears_load_err");

      foreach (vecs[i])
         apply4(vecs[i]);
      reset = 1'b0; en = 1'b0; load = 1'b0;

      // Single-decade instance corner sequences
      apply1(1,0,0,0,0,4'h0,4'h0,0,0,"d1_reset");
      apply1(0,1,1,0,0,4'h0,4'h1,0,0,"d1_up");
      apply1(0,0,0,1,0,4'h9,4'h9,0,0,"d1_load_9");
      apply1(0,1,1,0,0,4'h0,4'h0,1,0,"d1_wrap_up");
      apply1(0,1,0,0,0,4'h0,4'h9,1,0,"d1_wrap_down");
      apply1(0,1,0,0,0,4'h0,4'h8,0,0,"d1_down");
      apply1(0,0,0,1,0,4'hA,4'h8,0,1,"d1_bad_load");
      apply1(0,0,0,1,1,4'h9,4'h9,0,0,"d1_load_9_sat");
      apply1(0,1,1,0,1,4'h0,4'h9,1,0,"d1_sat_max");
      apply1(0,1,1,0,1,4'h0,4'h9,1,0,"d1_sat_max_again");
      apply1(0,0,0,1,1,4'h0,4'h0,0,0,"d1_load_0_sat");
      apply1(0,1,0,0,1,4'h0,4'h0,1,0,"d1_sat_min");
      apply1(0,1,1,0,1,4'h0,4'h1,0,0,"d1_up_from_min");

      if (sb4.size() != 0 || sb1.size() != 0) begin
         applied++; miscompares++;
         $display("FAIL scoreboard_drain: left %0d/%0d entries, required 0/0",
                  sb4.size(), sb1.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not complete within 50000 time units");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bcd_updown_counter_n.md
Name: bcd_updown_counter_n

Overview:
Parametrised multi-digit BCD up/down counter. It generalises the single-digit BCD up/down counter to DIGITS cascaded decades. It adds count enable, synchronous parallel load with BCD validity checking, wrap/saturate mode, and a terminal-count pulse. It serves as the decimal event/tick counter for display and timer paths, and its count output drives 7-segment decoders directly.

Parameters:
DIGITS, 4, number of BCD decades (1..8); count width = 4*DIGITS.

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  count enable; 1 = step one count this edge
up_down  input  1  direction; 1 = up, 0 = down
load  input  1  synchronous parallel load request
load_val  input  4*DIGITS  BCD value to load; digit i at bits [4i+3:4i], digit 0 = least significant
sat_mode  input  1  0 = wrap at bounds, 1 = saturate at bounds
count  output  4*DIGITS  registered BCD count; every nibble is always 0..9
tc  output  1  registered terminal-count pulse
load_err  output  1  registered pulse; last load was rejected

Behaviour:
- All outputs are registers. No combinational path from inputs to outputs. Input effects appear after 1 clk edge.
- Priority per edge: reset > load > en. up_down and sat_mode are sampled only when en is acted on.
- Reset (reset=1): count=0, tc=0, load_err=0. This overrides load/en asserted in the same cycle. Mid-count reset clears everything on that edge.
- Load (load=1, reset=0):
  - If every nibble of load_val is <= 9: count<=load_val, load_err<=0.
  - If any nibble is > 9: count unchanged, load_err<=1 for one cycle.
  - tc<=0 in both cases. en is ignored that edge.
- Hold (en=0, load=0): count unchanged, tc<=0, load_err<=0.
- Up step (en=1, up_down=1):
  - Digit i increments iff all digits below i equal 9.
  - Any digit that equals 9 and whose lower digits are all 9 goes to 0. Digit 0 always steps.
- Down step (en=1, up_down=0):
  - Digit i decrements iff all digits below i equal 0.
  - A digit at 0 whose lower digits are all 0 goes to 9.
- Upper bound, count = all 9s (MAX) with up step:
  - sat_mode=0: count<=0, tc<=1.
  - sat_mode=1: count stays MAX, tc<=1.
- Lower bound, count = 0 with down step:
  - sat_mode=0: count<=MAX, tc<=1.
  - sat_mode=1: count stays 0, tc<=1.
- Any non-boundary step: tc<=0, load_err<=0.
- tc timing: tc is high exactly in the cycle in which count shows the wrapped or held boundary value. In saturate mode it re-asserts on every enabled step attempted at the bound.
- Direction reversal: up_down may toggle on any cycle. There is no dead cycle; the next enabled edge steps in the new direction.
- count never holds a non-BCD nibble. No state path can produce one.
- DIGITS=1 must behave as a 0..9 single-decade counter with the added features.

Test Plan:
- Reset, then en=1, up_down=1, DIGITS=4, 12 edges -> count 0x0000..0x0009, 0x0010, 0x0011; tc=0 throughout.
- Load 0x0099, then 1 up step -> 0x0100. Load 0x9999, then 1 up step with sat_mode=0 -> count 0x0000, tc=1 for one cycle, next step 0x0001 with tc=0.
- From 0x0000, down step with sat_mode=0 -> 0x9999 with tc=1. Then 0x9998. Load 0x1000, then down -> 0x0999.
- sat_mode=1: load 0x9999, 3 up steps -> count stays 0x9999, tc=1 on each. Then up_down=0 -> 0x9998, tc=0. At 0x0000, down steps -> hold at 0x0000 with tc=1.
- Load 0x12A4 while count=0x0042 -> count stays 0x0042, load_err=1 for one cycle. Load 0x1234 -> count 0x1234, load_err=0. load=1 and en=1 together -> load wins, no step.
- Mid-count at 0x0457 with en=1 and load=1, assert reset one cycle -> count 0x0000, tc=0, load_err=0. Counting resumes from 0x0001 after reset deasserts.
